// File: rtl/rf_op_sequencer_pkg.sv
// Shared types and defaults for the register-file operation sequencer:
// ALU operation codes, FSM state encoding and datapath widths.
package rf_op_sequencer_pkg;

  localparam int WIDTH = 16;
  localparam int AW    = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Register-file bus between the sequencer (master) and the 4x16 file (slave).
// One combinational read port selected by rf_rsel, one write port strobed by
// the active-low rf_we.
interface rf_op_sequencer_if #(
  parameter int WIDTH = rf_op_sequencer_pkg::WIDTH,
  parameter int AW    = rf_op_sequencer_pkg::AW
);

  logic [AW-1:0]    rf_rsel;
  logic [WIDTH-1:0] rf_q;
  logic [AW-1:0]    rf_wsel;
  logic [WIDTH-1:0] rf_d;
  logic             rf_we;

  modport master (
    output rf_rsel,
    output rf_wsel,
    output rf_d,
    output rf_we,
    input  rf_q
  );

  modport slave (
    input  rf_rsel,
    input  rf_wsel,
    input  rf_d,
    input  rf_we,
    output rf_q
  );

endinterface

// File: rtl/rf_op_sequencer_alu.sv
// Combinational ALU used in the EXEC step. Arithmetic wraps modulo 2^WIDTH;
// o_c is the ADD carry-out, the SUB borrow (a < b unsigned), and 0 for logic ops.
module rf_op_sequencer_alu
  import rf_op_sequencer_pkg::*;
#(
  parameter int WIDTH = rf_op_sequencer_pkg::WIDTH
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_c
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  // Select the result and carry/borrow for the requested operation
  always_comb begin
    o_y = '0;
    o_c = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_y = w_sum[WIDTH-1:0];
        o_c = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_y = i_a - i_b;
        o_c = (i_a < i_b);
      end
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      default: begin
        o_y = '0;
        o_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Initiator side of the 4x16 register file. Takes one command (op, ra, rb, rd)
// and walks IDLE -> RD_A -> RD_B -> EXEC -> WB over the single read port,
// writing the result back with a one-cycle active-low strobe.
// All bus outputs are decoded from registered state so nothing on the bus
// depends combinationally on the command inputs.
module rf_op_sequencer
  import rf_op_sequencer_pkg::*;
#(
  parameter int WIDTH = rf_op_sequencer_pkg::WIDTH,
  parameter int AW    = rf_op_sequencer_pkg::AW
) (
  input  logic          ck,
  input  logic          res,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rd,
  output logic          busy,
  output logic          done,
  output logic          flag_z,
  output logic          flag_c,
  rf_op_sequencer_if.master rfBus
);

  state_t           r_state;
  op_t              r_opL;
  logic [AW-1:0]    r_raL;
  logic [AW-1:0]    r_rbL;
  logic [AW-1:0]    r_rdL;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [AW-1:0]    r_wsel;
  logic             r_done;
  logic             r_flagZ;
  logic             r_flagC;

  logic [WIDTH-1:0] w_aluY;
  logic             w_aluC;

  rf_op_sequencer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op (r_opL),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_y  (w_aluY),
    .o_c  (w_aluC)
  );

  // Command FSM: latches the command, fetches both operands, executes, writes back
  always_ff @(posedge ck) begin
    if (!res) begin
      r_state  <= S_IDLE;
      r_opL    <= OP_ADD;
      r_raL    <= '0;
      r_rbL    <= '0;
      r_rdL    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_wsel   <= '0;
      r_done   <= 1'b0;
      r_flagZ  <= 1'b0;
      r_flagC  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opL   <= op_t'(op);
            r_raL   <= ra;
            r_rbL   <= rb;
            r_rdL   <= rd;
            r_state <= S_RD_A;
          end
        end
        S_RD_A: begin
          r_a     <= rfBus.rf_q;
          r_state <= S_RD_B;
        end
        S_RD_B: begin
          r_b     <= rfBus.rf_q;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_aluY;
          r_flagZ  <= (w_aluY == '0);
          r_flagC  <= w_aluC;
          r_wsel   <= r_rdL;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign flag_z = r_flagZ;
  assign flag_c = r_flagC;

  assign rfBus.rf_rsel = (r_state == S_RD_B) ? r_rbL : r_raL;
  assign rfBus.rf_we   = (r_state != S_WB);
  assign rfBus.rf_wsel = r_wsel;
  assign rfBus.rf_d    = r_result;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench for rf_op_sequencer with a behavioural 4x16 register file on
// the bus. Expected write-backs are queued when a command is issued and
// popped by the register-file model when the sequencer actually writes.
module tb_rf_op_sequencer;
  import rf_op_sequencer_pkg::*;

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        ck;
  logic        res;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  ra;
  logic [1:0]  rb;
  logic [1:0]  rd;
  logic        busy;
  logic        done;
  logic        flag_z;
  logic        flag_c;

  logic [15:0] regs [4];
  logic [15:0] shadow [4];
  wr_t         expQ [$];
  logic        expZ;
  logic        expC;
  int          checks;
  int          errors;
  int          writeCount;
  int          cycleCount;

  rf_op_sequencer_if #(.WIDTH(16), .AW(2)) rfBus ();

  rf_op_sequencer #(
    .WIDTH (16),
    .AW    (2)
  ) dut (
    .ck     (ck),
    .res    (res),
    .start  (start),
    .op     (op),
    .ra     (ra),
    .rb     (rb),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .rfBus  (rfBus)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Cycle counter used to measure command spacing
  initial cycleCount = 0;
  always @(posedge ck) cycleCount++;

  // Combinational read port of the register-file model
  assign rfBus.rf_q = regs[rfBus.rf_rsel];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-file write port: scoreboard every write against the queued expectation
  always @(posedge ck) begin
    if (rfBus.rf_we === 1'b0) begin
      writeCount++;
      checkOutput("wrPending", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wrAddr", 32'(rfBus.rf_wsel), 32'(e.addr));
        checkOutput("wrData", 32'(rfBus.rf_d), 32'(e.data));
      end
      regs[rfBus.rf_wsel] = rfBus.rf_d;
    end
  end

  function automatic logic [16:0] aluModel(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    case (o)
      2'd0:    r = {1'b0, a} + {1'b0, b};
      2'd1:    r = {(a < b), 16'(a - b)};
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  task automatic preload(input int idx, input logic [15:0] v);
    regs[idx]   = v;
    shadow[idx] = v;
  endtask

  // Drive a command with start=1 and queue the write-back the file should see
  task automatic applyStimulus(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
    logic [16:0] r;
    r = aluModel(o, shadow[a], shadow[b]);
    expQ.push_back('{addr: d, data: r[15:0]});
    shadow[d] = r[15:0];
    expZ = (r[15:0] == 16'h0);
    expC = r[16];
    op    = o;
    ra    = a;
    rb    = b;
    rd    = d;
    start = 1'b1;
  endtask

  // Wait (bounded) for the done pulse, sampling 1 unit after each edge
  task automatic waitDone(input string tag, output int doneCycle);
    bit seen;
    seen = 1'b0;
    doneCycle = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge ck);
      #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        doneCycle = cycleCount;
      end
    end
    checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
  endtask

  // Issue one command, wait for completion, then check write-back and flags
  task automatic runCmd(input string tag, input logic [1:0] o, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
    int dc;
    @(negedge ck);
    applyStimulus(o, a, b, d);
    @(posedge ck);
    #1;
    start = 1'b0;
    waitDone(tag, dc);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_z"}, 32'(flag_z), 32'(expZ));
    checkOutput({tag, "_c"}, 32'(flag_c), 32'(expC));
    checkOutput({tag, "_reg"}, 32'(regs[d]), 32'(shadow[d]));
    checkOutput({tag, "_qEmpty"}, 32'(expQ.size()), 32'd0);
    @(posedge ck);
    #1;
    checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
  endtask

  // Backstop so the run always ends even if something stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int d1;
    int d2;
    int w0;
    logic [15:0] saved3;

    checks     = 0;
    errors     = 0;
    writeCount = 0;
    for (int i = 0; i < 4; i++) begin
      regs[i]   = 16'h0;
      shadow[i] = 16'h0;
    end
    res   = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    ra    = 2'd0;
    rb    = 2'd0;
    rd    = 2'd0;

    // Reset held low for two cycles
    repeat (2) @(posedge ck);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(rfBus.rf_we), 32'd1);
    checkOutput("rst_z", 32'(flag_z), 32'd0);
    checkOutput("rst_c", 32'(flag_c), 32'd0);
    checkOutput("rst_rsel", 32'(rfBus.rf_rsel), 32'd0);
    @(negedge ck);
    res = 1'b1;

    // ADD r1+r2 -> r3, traced edge by edge
    preload(1, 16'h0003);
    preload(2, 16'h0005);
    @(negedge ck);
    applyStimulus(2'd0, 2'd1, 2'd2, 2'd3);
    @(posedge ck);
    #1;
    start = 1'b0;
    checkOutput("add_E0_busy", 32'(busy), 32'd1);
    checkOutput("add_E0_rsel", 32'(rfBus.rf_rsel), 32'd1);
    checkOutput("add_E0_we", 32'(rfBus.rf_we), 32'd1);
    @(posedge ck);
    #1;
    checkOutput("add_E1_rsel", 32'(rfBus.rf_rsel), 32'd2);
    checkOutput("add_E1_we", 32'(rfBus.rf_we), 32'd1);
    @(posedge ck);
    #1;
    checkOutput("add_E2_we", 32'(rfBus.rf_we), 32'd1);
    checkOutput("add_E2_rsel", 32'(rfBus.rf_rsel), 32'd1);
    @(posedge ck);
    #1;
    checkOutput("add_E3_we", 32'(rfBus.rf_we), 32'd0);
    checkOutput("add_E3_wsel", 32'(rfBus.rf_wsel), 32'd3);
    checkOutput("add_E3_d", 32'(rfBus.rf_d), 32'h0008);
    checkOutput("add_E3_done", 32'(done), 32'd0);
    @(posedge ck);
    #1;
    checkOutput("add_E4_we", 32'(rfBus.rf_we), 32'd1);
    checkOutput("add_E4_done", 32'(done), 32'd1);
    checkOutput("add_E4_busy", 32'(busy), 32'd0);
    checkOutput("add_E4_r3", 32'(regs[3]), 32'h0008);
    checkOutput("add_E4_z", 32'(flag_z), 32'd0);
    checkOutput("add_E4_c", 32'(flag_c), 32'd0);
    checkOutput("add_E4_dholdD", 32'(rfBus.rf_d), 32'h0008);
    @(posedge ck);
    #1;
    checkOutput("add_E5_done", 32'(done), 32'd0);

    // ADD with carry-out and zero result, destination equals source A
    preload(0, 16'hFFFF);
    preload(1, 16'h0001);
    runCmd("addCarry", 2'd0, 2'd0, 2'd1, 2'd0);
    checkOutput("addCarry_r0", 32'(regs[0]), 32'h0000);

    // start held high: AND then OR, each accepted only in IDLE
    preload(0, 16'hF0F0);
    preload(1, 16'hFF00);
    w0 = writeCount;
    @(negedge ck);
    applyStimulus(2'd2, 2'd0, 2'd1, 2'd2);
    @(posedge ck);
    #1;
    applyStimulus(2'd3, 2'd2, 2'd0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      @(posedge ck);
      #1;
      checkOutput("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge ck);
    #1;
    d1 = cycleCount;
    checkOutput("hold_done1", 32'(done), 32'd1);
    checkOutput("hold_writes1", 32'(writeCount - w0), 32'd1);
    checkOutput("hold_r2", 32'(regs[2]), 32'hF000);
    @(posedge ck);
    #1;
    start = 1'b0;
    checkOutput("hold_reaccept", 32'(busy), 32'd1);
    checkOutput("hold_doneLow", 32'(done), 32'd0);
    waitDone("hold2", d2);
    checkOutput("hold_spacing", 32'(d2 - d1), 32'd5);
    checkOutput("hold_writes2", 32'(writeCount - w0), 32'd2);
    checkOutput("hold_r3", 32'(regs[3]), 32'hF0F0);
    checkOutput("hold_z", 32'(flag_z), 32'd0);
    checkOutput("hold_c", 32'(flag_c), 32'd0);
    repeat (3) @(posedge ck);
    #1;
    checkOutput("hold_noExtra", 32'(writeCount - w0), 32'd2);

    // SUB with borrow, then SUB of a register with itself
    preload(2, 16'h0002);
    preload(3, 16'h0005);
    runCmd("subBorrow", 2'd1, 2'd2, 2'd3, 2'd2);
    checkOutput("subBorrow_r2", 32'(regs[2]), 32'hFFFD);
    runCmd("subSelf", 2'd1, 2'd3, 2'd3, 2'd1);
    checkOutput("subSelf_r1", 32'(regs[1]), 32'h0000);

    // Reset while in EXEC aborts the command
    preload(1, 16'h1234);
    preload(2, 16'h1111);
    saved3 = shadow[3];
    w0 = writeCount;
    @(negedge ck);
    applyStimulus(2'd0, 2'd1, 2'd2, 2'd3);
    @(posedge ck);
    #1;
    start = 1'b0;
    @(posedge ck);
    @(posedge ck);
    @(negedge ck);
    res = 1'b0;
    @(posedge ck);
    #1;
    void'(expQ.pop_back());
    shadow[3] = saved3;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_we", 32'(rfBus.rf_we), 32'd1);
    checkOutput("abort_z", 32'(flag_z), 32'd0);
    @(negedge ck);
    res = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge ck);
      #1;
      checkOutput("abort_noDone", 32'(done), 32'd0);
    end
    checkOutput("abort_noWrite", 32'(writeCount - w0), 32'd0);
    checkOutput("abort_r3", 32'(regs[3]), 32'(saved3));

    // Normal command after the aborted one
    runCmd("postAbort", 2'd3, 2'd1, 2'd2, 2'd0);
    checkOutput("postAbort_r0", 32'(regs[0]), 32'h1335);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
